// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality check for the LSU stage.
package lsu_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // One flag covers ren&wen conflicts, illegal width codes and misalignment.
  function automatic logic lsu_err(input logic ren, input logic wen,
                                   input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    logic mis;
    if (ren) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else     bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return (ren && wen) || ((ren || wen) && (bad_f3 || mis));
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: picks the addressed byte/half of a raw word and extends it.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_raw[{i_addr, 3'b000} +: 8];
    w_h = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_b[7]}}, w_b};
      F3_BU:   o_data = {24'b0, w_b};
      F3_H:    o_data = {{16{w_h[15]}}, w_h};
      F3_HU:   o_data = {16'b0, w_h};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage: one load/store at a time over a valid/ready dmem port,
// formatted result handed to write-back over a valid/ready handshake.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] store_data,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [LANES-1:0] dmem_wmask,
  input  logic             dmem_resp_valid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             misalign_err
);

  state_t           r_state, w_next;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic             w_accept;
  logic             w_is_mem;
  logic             w_err;
  logic [LANES-1:0] w_lane_mask;
  logic [WIDTH-1:0] w_lane_data;
  logic [WIDTH-1:0] w_fmt;

  assign w_accept = in_valid && in_ready;
  assign w_is_mem = mem_ren || mem_wen;
  assign w_err    = lsu_err(mem_ren, mem_wen, funct3, alu_result[1:0]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_is_mem && !w_err) ? REQ : DONE;
      REQ:     if (dmem_req_ready) w_next = WAIT;
      WAIT:    if (dmem_resp_valid) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (r_state == IDLE);
    dmem_req_valid = (r_state == REQ);
    out_valid      = (r_state == DONE);
  end

  // Store lane steering: narrow data is replicated so any lane sees it.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_lane_mask = 4'b0001 << alu_result[1:0];
        w_lane_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_lane_mask = 4'b0011 << alu_result[1:0];
        w_lane_data = {2{store_data[15:0]}};
      end
      default: begin
        w_lane_mask = 4'b1111;
        w_lane_data = store_data;
      end
    endcase
  end

  lsu_load_fmt u_fmt (
    .i_funct3 (r_f3),
    .i_addr   (r_off),
    .i_raw    (dmem_rdata),
    .o_data   (w_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3         <= '0;
      r_off        <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wmask   <= '0;
      out_data     <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_f3         <= funct3;
        r_off        <= alu_result[1:0];
        misalign_err <= w_err;
        out_data     <= w_is_mem ? '0 : alu_result;
        // Bus fields only change for ops that will actually reach the bus.
        if (w_is_mem && !w_err) begin
          dmem_we    <= mem_wen;
          dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
          dmem_wdata <= mem_wen ? w_lane_data : '0;
          dmem_wmask <= mem_wen ? w_lane_mask : '0;
        end
      end
      if (r_state == WAIT && dmem_resp_valid)
        out_data <= dmem_we ? '0 : w_fmt;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: pass-through, loads, stores, errors, stalls, reset abort.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mem_ren, mem_wen;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp_valid;
  logic        out_valid, out_ready, misalign_err;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
    .alu_result(alu_result), .store_data(store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .misalign_err(misalign_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Minimum-latency memory op: handshake on the first REQ cycle, response sampled two edges later.
  task automatic mem_op(input string tag, input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_mask, input logic [31:0] exp_out);
    in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3;
    alu_result = addr; store_data = sd; dmem_req_ready = 1'b1;
    step();
    in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    chk1({tag, ".req_valid"}, dmem_req_valid, 1'b1);
    chk1({tag, ".in_ready"}, in_ready, 1'b0);
    chk ({tag, ".addr"}, dmem_addr, exp_addr);
    chk1({tag, ".we"}, dmem_we, wen);
    chk ({tag, ".wdata"}, dmem_wdata, exp_wdata);
    chk ({tag, ".wmask"}, {28'b0, dmem_wmask}, {28'b0, exp_mask});
    step();
    dmem_req_ready = 1'b0;
    chk1({tag, ".req_drop"}, dmem_req_valid, 1'b0);
    step();
    chk1({tag, ".no_early_out"}, out_valid, 1'b0);
    dmem_resp_valid = 1'b1; dmem_rdata = rd;
    step();
    dmem_resp_valid = 1'b0;
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk ({tag, ".out_data"}, out_data, exp_out);
    chk1({tag, ".err"}, misalign_err, 1'b0);
    step();
    chk1({tag, ".back_idle"}, in_ready, 1'b1);
  endtask

  task automatic err_op(input string tag, input logic ren, input logic wen,
                        input logic [2:0] f3, input logic [31:0] addr);
    in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3;
    alu_result = addr; store_data = 32'h1111_2222;
    step();
    in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk1({tag, ".err"}, misalign_err, 1'b1);
    chk ({tag, ".out_data"}, out_data, 32'h0);
    chk1({tag, ".no_req"}, dmem_req_valid, 1'b0);
    step();
    chk1({tag, ".back_idle"}, in_ready, 1'b1);
    chk1({tag, ".no_req2"}, dmem_req_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'b000;
    alu_result = '0; store_data = '0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    dmem_rdata = '0; out_ready = 1'b1;
    step(); step();
    chk1("rst.in_ready", in_ready, 1'b1);
    chk1("rst.req_valid", dmem_req_valid, 1'b0);
    chk1("rst.we", dmem_we, 1'b0);
    chk ("rst.addr", dmem_addr, 32'h0);
    chk ("rst.wdata", dmem_wdata, 32'h0);
    chk ("rst.wmask", {28'b0, dmem_wmask}, 32'h0);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk ("rst.out_data", out_data, 32'h0);
    chk1("rst.err", misalign_err, 1'b0);
    rst = 1'b0;
    step();
    chk1("post_rst.in_ready", in_ready, 1'b1);

    // Pass-through: result one cycle after accept, no bus traffic.
    in_valid = 1'b1; alu_result = 32'h0000_1234; dmem_req_ready = 1'b1;
    step();
    in_valid = 1'b0; alu_result = 32'hFFFF_FFFF;
    chk1("pt.out_valid", out_valid, 1'b1);
    chk ("pt.out_data", out_data, 32'h0000_1234);
    chk1("pt.err", misalign_err, 1'b0);
    chk1("pt.no_req", dmem_req_valid, 1'b0);
    chk1("pt.in_ready", in_ready, 1'b0);
    step();
    dmem_req_ready = 1'b0;
    chk1("pt.idle", in_ready, 1'b1);
    chk1("pt.out_drop", out_valid, 1'b0);
    chk1("pt.no_req2", dmem_req_valid, 1'b0);

    mem_op("lb",  1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    mem_op("lbu", 1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080);
    mem_op("lh",  1, 0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 32'h8000_0004, 32'h0, 4'b0000, 32'hFFFF_8001);
    mem_op("lhu", 1, 0, 3'b101, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 32'h8000_0004, 32'h0, 4'b0000, 32'h0000_8001);
    mem_op("lhlo",1, 0, 3'b001, 32'h8000_0004, 32'h0, 32'h8001_7FFF, 32'h8000_0004, 32'h0, 4'b0000, 32'h0000_7FFF);
    mem_op("lw",  1, 0, 3'b010, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 32'h1000_0008, 32'h0, 4'b0000, 32'hCAFE_F00D);
    mem_op("sh",  0, 1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 32'h0);
    mem_op("sb",  0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h1234_5678, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0);
    mem_op("sw",  0, 1, 3'b010, 32'h8000_000C, 32'h0BAD_CAFE, 32'h1234_5678, 32'h8000_000C, 32'h0BAD_CAFE, 4'b1111, 32'h0);

    err_op("mis_lw", 1, 0, 3'b010, 32'h8000_0001);
    err_op("mis_lh", 1, 0, 3'b001, 32'h8000_0003);
    err_op("mis_sw", 0, 1, 3'b010, 32'h8000_0002);
    err_op("bad_ld", 1, 0, 3'b011, 32'h8000_0000);
    err_op("bad_st", 0, 1, 3'b100, 32'h8000_0000);
    err_op("rw_both", 1, 1, 3'b010, 32'h8000_0000);

    // Stalls: req_ready low 3 cycles, stray resp during REQ, out_ready low 2 cycles.
    in_valid = 1'b1; mem_ren = 1'b1; funct3 = 3'b010; alu_result = 32'h8000_0010;
    dmem_req_ready = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b0; mem_ren = 1'b0; alu_result = 32'h5555_5555;
    chk1("st.req0", dmem_req_valid, 1'b1);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_resp_valid = 1'b0;
    chk1("st.req1", dmem_req_valid, 1'b1);
    chk ("st.addr1", dmem_addr, 32'h8000_0010);
    step();
    chk1("st.req2", dmem_req_valid, 1'b1);
    chk ("st.addr2", dmem_addr, 32'h8000_0010);
    chk1("st.in_ready2", in_ready, 1'b0);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk1("st.req_drop", dmem_req_valid, 1'b0);
    chk1("st.wait_out", out_valid, 1'b0);
    step();
    chk1("st.wait_out2", out_valid, 1'b0);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    step();
    dmem_resp_valid = 1'b0; dmem_rdata = 32'hFFFF_0000;
    chk1("st.out_valid6", out_valid, 1'b1);
    chk ("st.out_data6", out_data, 32'h1357_9BDF);
    chk1("st.in_ready6", in_ready, 1'b0);
    step();
    chk1("st.hold1", out_valid, 1'b1);
    chk ("st.hold1_data", out_data, 32'h1357_9BDF);
    chk1("st.hold1_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    chk1("st.idle", in_ready, 1'b1);
    chk1("st.out_drop", out_valid, 1'b0);

    // Reset while waiting for a response; the late response must be ignored.
    in_valid = 1'b1; mem_ren = 1'b1; funct3 = 3'b010; alu_result = 32'h8000_0020;
    dmem_req_ready = 1'b1;
    step();
    in_valid = 1'b0; mem_ren = 1'b0;
    step();
    dmem_req_ready = 1'b0;
    chk1("ra.in_wait", dmem_req_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("ra.in_ready", in_ready, 1'b1);
    chk1("ra.out_valid", out_valid, 1'b0);
    chk ("ra.out_data", out_data, 32'h0);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_resp_valid = 1'b0;
    chk1("ra.late_out", out_valid, 1'b0);
    chk1("ra.late_in_ready", in_ready, 1'b1);
    step();
    chk1("ra.late_out2", out_valid, 1'b0);
    chk1("ra.late_req", dmem_req_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage directly downstream of the execute unit in the npc core.
- Consumes the ALU result as the effective address (or passes it through for non-memory ops) and rs2 as store data.
- Performs one load/store over a valid/ready data-memory port and returns formatted load data to write-back over a valid/ready handshake.
- Multi-cycle FSM; accepts one operation at a time.

Parameters:
WIDTH, 32, datapath/address width; only 32 is supported (byte-lane logic is 4 lanes).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept op
mem_ren  in  1  op is a load
mem_wen  in  1  op is a store
funct3  in  3  RISC-V width/sign code
alu_result  in  WIDTH  EXU result: effective address or pass-through value
store_data  in  WIDTH  rs2 value
dmem_req_valid  out  1  memory request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1=write, 0=read
dmem_addr  out  WIDTH  word-aligned address (low 2 bits zero)
dmem_wdata  out  WIDTH  lane-aligned store data
dmem_wmask  out  4  byte-lane write enables
dmem_resp_valid  in  1  read data / write ack valid
dmem_rdata  in  WIDTH  raw read word
out_valid  out  1  result valid to write-back
out_ready  in  1  write-back accepts result
out_data  out  WIDTH  load value, pass-through value, or 0 for stores
misalign_err  out  1  qualified by out_valid; access rejected

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset:
  - State goes to IDLE.
  - dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, out_valid, out_data and misalign_err are all 0.
  - in_ready is 1 in the first cycle after reset.
- Registered outputs: all outputs except in_ready are registered/state-decoded. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready, latch all inputs.
  - Non-memory op (mem_ren=mem_wen=0): go to DONE with out_data=alu_result and err=0.
  - Error case: go to DONE with err=1 and out_data=0, with no bus activity. Error is any of:
    - mem_ren & mem_wen both set;
    - illegal funct3 (load: 011/110/111; store: anything other than 000/001/010);
    - misalignment (half: addr[0]!=0; word: addr[1:0]!=0).
  - Otherwise go to REQ.
- REQ:
  - dmem_req_valid=1.
  - Address/data/mask/we stay stable until dmem_req_ready.
  - On handshake go to WAIT and drop dmem_req_valid.
- WAIT:
  - On dmem_resp_valid, capture and format the data, then go to DONE.
  - Stores ignore rdata and set out_data=0.
- DONE:
  - out_valid=1 and out_data stable until out_ready.
  - On out_ready go to IDLE.
  - in_ready stays 0 throughout DONE (no bypass).
- Store lanes (a=addr[1:0]):
  - sb: mask=0001<<a, wdata={4{data[7:0]}}.
  - sh: mask=0011<<a, wdata={2{data[15:0]}}.
  - sw: mask=1111, wdata=data.
  - Loads drive mask=0000.
- Load format:
  - lb/lbu: select byte a; sign- or zero-extend.
  - lh/lhu: select half a[1]; sign- or zero-extend.
  - lw: whole word.
- Latency (accept edge to out_valid):
  - Pass-through and error ops: 1 cycle.
  - Memory ops: 3 cycles minimum with req_ready=1 and resp_valid the cycle after the request; each ready/resp stall adds 1 cycle.
- Boundaries:
  - dmem_resp_valid outside WAIT is ignored.
  - dmem_req_ready outside REQ is ignored.
  - rst in any state aborts the op with no partial result; an outstanding memory response arriving afterwards is ignored.
  - If out_ready is held 0, the result is held indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state encoding IDLE/REQ/WAIT/DONE;
  - lane-count constant 4.
- One combinational sub-module, lsu_load_fmt: inputs funct3, addr[1:0] and raw word; output the extended value. Also reused by the verification model.

Test Plan:
- Pass-through: alu_result=0x0000_1234, no ren/wen -> out_valid 1 cycle after accept, out_data=0x0000_1234, no dmem_req_valid ever.
- Load lb: addr 0x8000_0003, rdata=0x80FF_0000 -> dmem_addr=0x8000_0000, out_data=0xFFFF_FF80. lbu at the same address -> 0x0000_0080.
- Store sh: addr 0x8000_0002, store_data=0xDEAD_BEEF -> dmem_we=1, wmask=1100, wdata=0xBEEF_BEEF; out_data=0 after resp.
- Misaligned lw at 0x8000_0001 -> no bus request, out_valid next cycle with misalign_err=1 and out_data=0.
- Stalls: req_ready low 3 cycles, resp 2 cycles later, out_ready low 2 cycles -> dmem_* held stable, out_data held, in_ready=0 until out handshake; total accept-to-out_valid = 6 cycles.
- rst asserted in WAIT, then late dmem_resp_valid -> state IDLE, in_ready=1, out_valid stays 0, response ignored.
